load_store_ctrl: RTL

//  Load/store controller between the multi-cycle core's execute stage and the byte-addressable memory block.

---
 rtl/load_store_ctrl_if.sv | 41 ++++
 rtl/load_store_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/load_store_ctrl_if.sv
// Core-side request/response handshake plus the memory port of the load/store controller.
// The controller uses the slave view; the core and memory model use the master view.
interface load_store_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [2:0]  req_funct3;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [2:0]  resp_fault;
  logic        mem_wr_en;
  logic [31:0] mem_address;
  logic [31:0] mem_in_val;
  logic [1:0]  mem_size;
  logic        mem_sz_ex_sel;
  logic [31:0] mem_out_val;

  // valid/ready: a transfer happens on a rising edge where both are 1; the
  // sender holds its payload stable from raising valid until that edge.
  modport slave (
    input  req_valid, req_wr, req_funct3, req_base, req_offset, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_fault,
    input  resp_ready,
    output mem_wr_en, mem_address, mem_in_val, mem_size, mem_sz_ex_sel,
    input  mem_out_val
  );

  modport master (
    output req_valid, req_wr, req_funct3, req_base, req_offset, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_fault,
    output resp_ready,
    input  mem_wr_en, mem_address, mem_in_val, mem_size, mem_sz_ex_sel,
    output mem_out_val
  );
endinterface

// File: rtl/load_store_ctrl.sv
// Load/store controller: computes base+offset, screens for faults, runs one
// memory access and returns data or a fault code over a valid/ready response.
module load_store_ctrl #(
  parameter int unsigned MEM_BYTES  = 256,
  parameter int unsigned IMEM_LIMIT = 64,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  load_store_ctrl_if.slave     bus,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    MEM  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] F_OK  = 3'd0;
  localparam logic [2:0] F_MIS = 3'd1;
  localparam logic [2:0] F_WP  = 3'd2;
  localparam logic [2:0] F_OOR = 3'd3;
  localparam logic [2:0] F_ILL = 3'd4;

  state_t      state_q;
  logic        wr_q;
  logic [2:0]  funct3_q;
  logic [31:0] base_q;
  logic [31:0] offset_q;
  logic [31:0] wdata_q;
  logic [2:0]  cnt_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic [2:0]  resp_fault_q;
  logic        mem_wr_en_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_in_val_q;
  logic [1:0]  mem_size_q;
  logic        mem_sz_ex_sel_q;

  logic [31:0] ea_d;
  logic [2:0]  fault_d;
  logic [31:0] ld_data_d;
  logic        sx;

  always_comb begin
    ea_d    = base_q + offset_q;
    fault_d = F_OK;
    // Priority: illegal encoding, then alignment, then range, then protection.
    if (funct3_q == 3'b011 || funct3_q == 3'b110 || funct3_q == 3'b111 ||
        (wr_q && funct3_q[2])) begin
      fault_d = F_ILL;
    end else if ((funct3_q[1:0] == 2'b01 && ea_d[0]) ||
                 (funct3_q[1:0] == 2'b10 && ea_d[1:0] != 2'b00)) begin
      fault_d = F_MIS;
    end else if (ea_d >= MEM_BYTES) begin
      fault_d = F_OOR;
    end else if (wr_q && ea_d < IMEM_LIMIT) begin
      fault_d = F_WP;
    end

    sx = ~funct3_q[2];
    case (funct3_q[1:0])
      2'b00:   ld_data_d = {{24{sx & bus.mem_out_val[7]}},  bus.mem_out_val[7:0]};
      2'b01:   ld_data_d = {{16{sx & bus.mem_out_val[15]}}, bus.mem_out_val[15:0]};
      default: ld_data_d = bus.mem_out_val;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      wr_q            <= 1'b0;
      funct3_q        <= 3'd0;
      base_q          <= 32'd0;
      offset_q        <= 32'd0;
      wdata_q         <= 32'd0;
      cnt_q           <= 3'd0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 32'd0;
      resp_fault_q    <= F_OK;
      mem_wr_en_q     <= 1'b0;
      mem_address_q   <= 32'd0;
      mem_in_val_q    <= 32'd0;
      mem_size_q      <= 2'd0;
      mem_sz_ex_sel_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            wr_q        <= bus.req_wr;
            funct3_q    <= bus.req_funct3;
            base_q      <= bus.req_base;
            offset_q    <= bus.req_offset;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= CALC;
          end
        end
        CALC: begin
          if (fault_d != F_OK) begin
            resp_fault_q <= fault_d;
            resp_rdata_q <= 32'd0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            mem_address_q   <= ea_d;
            mem_size_q      <= funct3_q[1:0];
            mem_sz_ex_sel_q <= ~funct3_q[2];
            mem_wr_en_q     <= wr_q;
            if (wr_q) begin
              mem_in_val_q <= wdata_q;
            end
            cnt_q   <= 3'd0;
            state_q <= MEM;
          end
        end
        MEM: begin
          if (wr_q) begin
            mem_wr_en_q  <= 1'b0;
            resp_fault_q <= F_OK;
            resp_rdata_q <= 32'd0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (cnt_q == 3'(MEM_RD_LAT - 1)) begin
            resp_fault_q <= F_OK;
            resp_rdata_q <= ld_data_d;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.resp_fault    = resp_fault_q;
  assign bus.mem_wr_en     = mem_wr_en_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_in_val    = mem_in_val_q;
  assign bus.mem_size      = mem_size_q;
  assign bus.mem_sz_ex_sel = mem_sz_ex_sel_q;
  assign dbg_state_o       = state_q;

endmodule
